// File: rtl/hdmi_pix_fetch.sv
// Framebuffer scan-out: prefetches packed greyscale words into a small FIFO and
// unpacks them MSB-first into PBW-bit pixels, 2 cycles behind hs/vs/de.
module hdmi_pix_fetch #(
    parameter int          HBW         = 12,
    parameter int          VBW         = 11,
    parameter int          PBW         = 24,
    parameter int          WORD_W      = 64,
    parameter int          BPP         = 8,
    parameter int          AW          = 19,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FRAME_WORDS = 259200,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              de_in,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic [PBW-1:0]    data_out,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              underflow
);

    localparam int C   = PBW / 3;
    localparam int PPW = WORD_W / BPP;
    localparam int IW  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int NW  = $clog2(FRAME_WORDS + 1);

    localparam logic [AW-1:0] BASE    = AW'(BASE_ADDR);
    localparam logic [NW-1:0] FW      = NW'(FRAME_WORDS);
    localparam logic [IW-1:0] LAST    = IW'(PPW - 1);
    localparam logic [CW:0]   DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    // HBW/VBW size the upstream timing generator; here they are only sanity-checked.
    generate
        if (HBW < 1 || VBW < 1 || PBW % 3 != 0 || WORD_W % BPP != 0 ||
            FIFO_DEPTH < 4 || (1 << FAW) != FIFO_DEPTH) begin : g_bad_params
            $error("hdmi_pix_fetch: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_FETCH, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              vs_q;
    logic              mem_req_q, mem_req_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [NW-1:0]     issued_q, issued_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     pix_idx_q, pix_idx_d;
    logic [WORD_W-1:0] sr_q, sr_d, cur;
    logic              uf_q, uf_d;
    logic [BPP-1:0]    pix1_q, pix1_d;
    logic              hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q;
    logic [PBW-1:0]    data_q, data_d;
    logic [C-1:0]      chan;
    logic              vs_rise, acc, rv_ok, streaming, fifo_empty, push, pop;

    assign vs_rise    = vs_in & ~vs_q;
    assign acc        = mem_req_q & mem_ack;
    // A response with nothing outstanding belongs to a request lost across reset.
    assign rv_ok      = mem_rvalid & (outst_q != '0);
    assign streaming  = (state_q == S_FETCH) || (state_q == S_DONE);
    assign fifo_empty = (cnt_q == '0);
    assign push       = rv_ok & streaming & ~vs_rise;
    assign pop        = de_in & (pix_idx_q == '0) & ~fifo_empty;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (vs_rise) state_d = S_FLUSH;
            S_FLUSH: if (outst_q == '0) state_d = S_FETCH;
            S_FETCH: if (issued_q == FW) state_d = S_DONE;
            default: state_d = state_q;
        endcase
        if (vs_rise) state_d = S_FLUSH;
    end

    // One request in flight on the port at a time; the credit check counts it
    // before raising, so fifo + outstanding can never exceed FIFO_DEPTH.
    always_comb begin
        mem_req_d = mem_req_q;
        addr_d    = addr_q;
        issued_d  = issued_q;
        if (acc) begin
            mem_req_d = 1'b0;
            addr_d    = addr_q + 1'b1;
            issued_d  = issued_q + 1'b1;
        end else if (state_q == S_FETCH && !mem_req_q && issued_q != FW &&
                     ({1'b0, cnt_q} + {1'b0, outst_q}) < DEPTH_L) begin
            mem_req_d = 1'b1;
        end
        if (vs_rise) begin
            mem_req_d = 1'b0;
            addr_d    = BASE;
            issued_d  = '0;
        end
    end

    always_comb begin
        outst_d = outst_q;
        case ({acc, rv_ok})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (vs_rise) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_q] <= mem_rdata;
    end

    // Stage 1: pixel extraction. An empty FIFO at a word boundary yields a black word.
    always_comb begin
        cur = sr_q;
        if (pix_idx_q == '0) cur = fifo_empty ? '0 : fifo_mem[rd_q];
        pix_idx_d = pix_idx_q;
        sr_d      = sr_q;
        pix1_d    = '0;
        uf_d      = uf_q;
        if (de_in) begin
            pix1_d    = cur[WORD_W-1 -: BPP];
            sr_d      = cur << BPP;
            pix_idx_d = (pix_idx_q == LAST) ? '0 : pix_idx_q + 1'b1;
            if (pix_idx_q == '0 && fifo_empty) uf_d = 1'b1;
        end
        if (vs_rise) begin
            pix_idx_d = '0;
            uf_d      = 1'b0;
        end
    end

    // Stage 2: MSB-first bit replication of BPP up to C bits per channel.
    for (genvar i = 0; i < C; i++) begin : g_rep
        assign chan[C-1-i] = pix1_q[BPP-1-(i % BPP)];
    end
    assign data_d = de1_q ? PBW'({3{chan}}) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            vs_q      <= 1'b0;
            mem_req_q <= 1'b0;
            addr_q    <= BASE;
            issued_q  <= '0;
            outst_q   <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            pix_idx_q <= '0;
            sr_q      <= '0;
            uf_q      <= 1'b0;
            pix1_q    <= '0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            de1_q     <= 1'b0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            de2_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            vs_q      <= vs_in;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            issued_q  <= issued_d;
            outst_q   <= outst_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            pix_idx_q <= pix_idx_d;
            sr_q      <= sr_d;
            uf_q      <= uf_d;
            pix1_q    <= pix1_d;
            hs1_q     <= hs_in;
            vs1_q     <= vs_in;
            de1_q     <= de_in;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            de2_q     <= de1_q;
            data_q    <= data_d;
        end
    end

    assign hs_out    = hs2_q;
    assign vs_out    = vs2_q;
    assign de_out    = de2_q;
    assign data_out  = data_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = addr_q;
    assign underflow = uf_q;

endmodule

// File: tb/tb_hdmi_pix_fetch.sv
// Randomized bench for hdmi_pix_fetch: memory with random ack/latency, queue-based
// pixel-stream reference model, scripted frames incl. stalls, short/long frames, reset.
module tb_hdmi_pix_fetch;

    localparam int PBW = 24, WORD_W = 64, BPP = 2, AW = 19;
    localparam int BASE = 100, FW = 24, DEPTH = 8;
    localparam int PPW = WORD_W / BPP, C = PBW / 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              hs_in, vs_in, de_in;
    logic              hs_out, vs_out, de_out;
    logic [PBW-1:0]    data_out;
    logic              mem_req, mem_ack, mem_rvalid, underflow;
    logic [AW-1:0]     mem_addr;
    logic [WORD_W-1:0] mem_rdata;

    always #5 clock = ~clock;

    hdmi_pix_fetch #(
        .HBW(12), .VBW(11), .PBW(PBW), .WORD_W(WORD_W), .BPP(BPP), .AW(AW),
        .BASE_ADDR(BASE), .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .data_out(data_out),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .underflow(underflow)
    );

    typedef struct { logic [63:0] d; int due; } resp_t;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, ack_pct = 100, lat_max = 1;
    bit e4_mode = 1'b0;

    // reference model state
    resp_t       pend[$];
    logic [63:0] mq[$];
    int          m_out, m_issued, m_pix;
    logic [63:0] m_word;
    bit          m_uf, m_active, m_flushing, vs_prev;
    logic        e1_hs, e1_vs, e1_de, e2_hs, e2_vs, e2_de;
    logic [BPP-1:0] e1_pix, e2_pix;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [PBW-1:0] expand(input logic [BPP-1:0] p);
        logic [C-1:0] c;
        c = '0;
        for (int i = 0; i < C / BPP; i++) c = (c << BPP) | C'(p);
        return {3{c}};
    endfunction

    task automatic model_clear();
        pend.delete(); mq.delete();
        m_out = 0; m_issued = 0; m_pix = 0; m_word = '0;
        m_uf = 0; m_active = 0; m_flushing = 0; vs_prev = 0;
        e1_hs = 0; e1_vs = 0; e1_de = 0; e1_pix = '0;
        e2_hs = 0; e2_vs = 0; e2_de = 0; e2_pix = '0;
    endtask

    task automatic step(input logic h, input logic v, input logic d);
        logic acc, rv, vr, fl_done, req_was;
        logic [AW-1:0] addr_was;
        logic [BPP-1:0] n_pix;
        logic [63:0] nd;
        resp_t r;
        hs_in = h; vs_in = v; de_in = d;
        mem_ack    = mem_req && ($urandom_range(99, 0) < ack_pct);
        rv         = (pend.size() > 0) && (pend[0].due <= cyc);
        mem_rvalid = rv;
        mem_rdata  = rv ? pend[0].d : {$urandom, $urandom};
        acc = mem_req && mem_ack;
        vr = v && !vs_prev;
        req_was = mem_req;
        addr_was = mem_addr;
        fl_done = m_flushing && (m_out == 0);
        if (acc) begin
            chk("req_addr", mem_addr, AW'(BASE + m_issued));
            chk("req_limit", m_issued < FW, 1);
            m_issued++;
        end
        n_pix = '0;
        if (d) begin
            if (m_pix == 0) begin
                if (mq.size() == 0) begin m_uf = 1'b1; m_word = '0; end
                else m_word = mq.pop_front();
            end
            n_pix = BPP'(m_word >> (WORD_W - (m_pix + 1) * BPP));
            m_pix = (m_pix + 1) % PPW;
        end
        if (rv) begin
            r = pend.pop_front();
            if (m_active && !vr) mq.push_back(r.d);
            m_out--;
        end
        if (acc) begin
            nd = e4_mode ? 64'hE4E4E4E4E4E4E4E4 : {$urandom, $urandom};
            pend.push_back('{nd, cyc + int'($urandom_range(lat_max, 1))});
            m_out++;
        end
        if (vr) begin
            mq.delete(); m_pix = 0; m_uf = 0; m_issued = 0;
            m_flushing = 1; m_active = 0;
        end else if (fl_done) begin
            m_flushing = 0; m_active = 1;
        end
        vs_prev = v;
        @(posedge clock); #1; cyc++;
        e2_hs = e1_hs; e2_vs = e1_vs; e2_de = e1_de; e2_pix = e1_pix;
        e1_hs = h; e1_vs = v; e1_de = d; e1_pix = n_pix;
        chk("hs_out", hs_out, e2_hs);
        chk("vs_out", vs_out, e2_vs);
        chk("de_out", de_out, e2_de);
        chk("data_out", data_out, e2_de ? expand(e2_pix) : '0);
        chk("underflow", underflow, m_uf);
        if (!m_active) chk("req_idle", mem_req, 0);
        if (req_was && !acc && !vr) chk("req_hold", {mem_req, mem_addr}, {1'b1, addr_was});
        chk("fill", (mq.size() + m_out) <= DEPTH, 1);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        hs_in = 0; vs_in = 0; de_in = 0; mem_ack = 0; mem_rvalid = 0;
        #1;
        chk("rst_zero", {hs_out, vs_out, de_out, data_out, mem_req, underflow}, '0);
        chk("rst_addr", mem_addr, AW'(BASE));
        model_clear();
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic run_frame(input int lines, input int de_len, input int blank);
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        for (int i = 0; i < 40; i++) step(i < 4, 0, 0);
        for (int l = 0; l < lines; l++) begin
            for (int i = 0; i < de_len; i++) step(0, 0, 1);
            for (int i = 0; i < blank; i++) step(i < 4, 0, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        hs_in = 0; vs_in = 0; de_in = 0; mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
        model_clear();
        @(posedge clock); #1;
        do_reset();
        for (int i = 0; i < 10; i++) step(0, 0, 0);

        ack_pct = 100; lat_max = 1;  run_frame(12, 64, 20);
        e4_mode = 1;                 run_frame(4, 64, 20);
        e4_mode = 0;
        ack_pct = 100; lat_max = 20; run_frame(6, 64, 12);
        ack_pct = 0;                 run_frame(3, 40, 10);
        ack_pct = 80;  lat_max = 5;  run_frame(14, 64, 20);
        ack_pct = 100; lat_max = 20; run_frame(1, 20, 4);

        // reset in the middle of an active line, then idle until a frame start
        ack_pct = 100; lat_max = 3;
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 0);
        for (int i = 0; i < 37; i++) step(0, 0, 1);
        do_reset();
        for (int i = 0; i < 30; i++) step(0, 0, 0);

        for (int f = 0; f < 5; f++) begin
            ack_pct = $urandom_range(100, 30);
            lat_max = $urandom_range(20, 1);
            run_frame($urandom_range(13, 2), $urandom_range(80, 16), $urandom_range(30, 8));
        end
        for (int i = 0; i < 20; i++) step(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
